mimo_unpack: RTL and testbench
==============================

// Module: mimo_unpack
// PURPOSE
//  Wide-to-narrow width converter: accepts one widthIn-bit word and emits it as widthIn/widthOut
//  narrow chunks, LSB chunk first. It is the transmit-side counterpart of the narrow-to-wide packer.
//  Sits between wide datapaths (DMA/memory beats) and narrow streaming consumers.
//  A one-entry hold register lets the next word be accepted while the current word drains,
//  so a continuously ready consumer receives one chunk per cycle with no bubble between words.
// PARAMETERS
//  widthIn   128  input word width; must be an integer multiple of widthOut (elaboration error otherwise)
//  widthOut  32   output chunk width; N = widthIn/widthOut chunks per word (N >= 2)
// PORTS
//  CLK             input   1          clock; all state updates on posedge
//  nRST            input   1          reset, synchronous, active-low
//  in$enq__ENA     input   1          enqueue strobe; takes effect only when in$enq__RDY = 1
//  in$enq$v        input   widthIn    word to unpack
//  in$enq$count    input   clog2(N+1) valid chunk count (present only with MIMO_UNPACK_PARTIAL_EN)
//  in$enq__RDY     output  1          can accept a word = !holdValid
//  out$deq__ENA    input   1          dequeue strobe; takes effect only when out$deq__RDY = 1
//  out$deq__RDY    output  1          c != 0
//  out$first       output  widthOut   current chunk = buffer[widthOut-1:0]
//  out$first__RDY  output  1          c != 0
//  out$last        output  1          c == 1; current chunk is the final chunk of its word
// BEHAVIOUR
//  State: buffer[widthIn-1:0]; c[clog2(N+1)-1:0] = chunks remaining; hold[widthIn-1:0], holdCount, holdValid.
//  Reset (nRST=0 at posedge): buffer=0, c=0, hold=0, holdValid=0 -> in$enq__RDY=1, out$deq__RDY=0,
//   out$first=0, out$first__RDY=0, out$last=0. Reset mid-word discards all buffered data; no partial output.
//  Legal states: EMPTY (c=0, !holdValid), ACTIVE (c>0, !holdValid), FULL (c>0, holdValid).
//   c=0 with holdValid=1 is unreachable; the bench asserts it never occurs.
//  deq fire, c>1: buffer <= buffer >> widthOut (zero-fill from the top); c <= c-1.
//  deq fire, c==1: if holdValid, buffer<=hold, c<=holdCount, holdValid<=0; else c<=0.
//  enq fire when c==0: buffer<=v, c<=N. First chunk is visible the next cycle (latency 1).
//  enq fire with deq fire at c==1 (hold is necessarily empty): buffer<=v, c<=N; no bubble.
//  enq fire in any other case, c>0: hold<=v, holdCount<=N, holdValid<=1.
//  In FULL, enq RDY=0. Out-of-order ENA without RDY is ignored; state is unchanged.
//  Transitions: EMPTY-enq->ACTIVE; ACTIVE-enq->FULL (unless last deq fires in the same cycle);
//   ACTIVE-last deq->EMPTY; FULL-last deq->ACTIVE.
//  out$first, out$last and the RDY outputs are decoded only from registers; there is no ENA->RDY combinational path.
// CONFIGURATION
//  MIMO_UNPACK_PARTIAL_EN defined: in$enq$count port exists. The loaded c/holdCount = count,
//   with count=0 or count>N treated as N. This allows short final words; out$last marks the true end.
//  Not defined: no count port; every word yields exactly N chunks.
// STRUCTURE
//  mimo_pkg (shared with the packer):
//   - function mimo_chunks(widthIn, widthOut)
//   - typedef mimo_state_t {EMPTY, ACTIVE, FULL} for bench and coverage
//   - localparam MIMO_CNT_W helper
//  Sub-module mimo_hold_reg: one-entry data+count register with valid, load and take controls;
//   reused by later gearboxes.
// TESTING (widthIn=128, widthOut=32)
//  1. Reset, enq 128'h44444444_33333333_22222222_11111111, deq ENA held 1 -> first = 11111111,
//     22222222, 33333333, 44444444 on consecutive cycles; last=1 on the 4th; then deq RDY=0.
//  2. enq A then B on back-to-back cycles, deq ENA held 1 -> 8 chunks with no gap;
//     enq RDY=0 from B's cycle until A's last deq.
//  3. Mid-word, deq ENA=0 for 5 cycles -> first and last stable, c unchanged, enq RDY=1.
//  4. Last deq and enq of C in the same cycle, hold empty -> next cycle first = C[31:0], c=4.
//  5. After 2 deqs, nRST=0 for one cycle -> deq RDY=0, first=0, enq RDY=1; held word is discarded.
//  6. With MIMO_UNPACK_PARTIAL_EN: count=2 -> 2 chunks, last on the 2nd;
//     count=0 and count=7 -> 4 chunks each.

Source files
------------

// File: rtl/mimo_pkg.sv
// Shared definitions for the mimo packer/unpacker family: chunk math, count width, occupancy states.
package mimo_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } mimo_state_t;

    function automatic int mimo_chunks(input int width_in, input int width_out);
        return width_in / width_out;
    endfunction

    function automatic int mimo_cnt_w(input int chunks);
        return $clog2(chunks + 1);
    endfunction

    localparam int MIMO_CNT_W = mimo_cnt_w(mimo_chunks(128, 32));

endpackage

// File: rtl/mimo_hold_reg.sv
// One-entry data+count holding register; load sets valid, take clears it; load wins if both.
// Latency 1 (registered outputs); no backpressure of its own, the owner gates load on !vld.
module mimo_hold_reg #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 3
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              load,
    input  logic [DATA_W-1:0] load_dat,
    input  logic [CNT_W-1:0]  load_cnt,
    input  logic              take,
    output logic              vld,
    output logic [DATA_W-1:0] dat,
    output logic [CNT_W-1:0]  cnt
);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            vld <= 1'b0;
            dat <= '0;
            cnt <= '0;
        end else if (load) begin
            vld <= 1'b1;
            dat <= load_dat;
            cnt <= load_cnt;
        end else if (take) begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/mimo_unpack.sv
// Wide-to-narrow unpacker, LSB chunk first; first chunk 1 cycle after enq, one chunk/cycle after.
// Backpressure: enq stalls only while a second word waits in the hold register. Option: MIMO_UNPACK_PARTIAL_EN.
module mimo_unpack
    import mimo_pkg::*;
#(
    parameter int width_in  = 128,
    parameter int width_out = 32,
    localparam int N        = mimo_chunks(width_in, width_out),
    localparam int CNT_W    = mimo_cnt_w(N)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 in_enq_ena,
    input  logic [width_in-1:0]  in_enq_v,
`ifdef MIMO_UNPACK_PARTIAL_EN
    input  logic [CNT_W-1:0]     in_enq_count,
`endif
    output logic                 in_enq_rdy,
    input  logic                 out_deq_ena,
    output logic                 out_deq_rdy,
    output logic [width_out-1:0] out_first,
    output logic                 out_first_rdy,
    output logic                 out_last
);

    if (((width_in % width_out) != 0) || (N < 2)) begin : g_bad_width
        $error("mimo_unpack: width_in must be a multiple of width_out with at least 2 chunks");
    end

    localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    logic [width_in-1:0] buffer;
    logic [CNT_W-1:0]    c;
    logic                hold_vld;
    logic [width_in-1:0] hold_dat;
    logic [CNT_W-1:0]    hold_cnt;
    logic [CNT_W-1:0]    enq_cnt;
    logic                enq_fire;
    logic                deq_fire;
    logic                deq_final;

`ifdef MIMO_UNPACK_PARTIAL_EN
    // Zero or oversize counts fall back to a full word rather than producing nothing.
    assign enq_cnt = ((in_enq_count == '0) || (in_enq_count > N_CNT)) ? N_CNT : in_enq_count;
`else
    assign enq_cnt = N_CNT;
`endif

    assign in_enq_rdy    = !hold_vld;
    assign out_deq_rdy   = (c != '0);
    assign out_first_rdy = (c != '0);
    assign out_first     = buffer[width_out-1:0];
    assign out_last      = (c == ONE_CNT);

    assign enq_fire  = in_enq_ena && in_enq_rdy;
    assign deq_fire  = out_deq_ena && out_deq_rdy;
    assign deq_final = deq_fire && (c == ONE_CNT);

    mimo_hold_reg #(
        .DATA_W (width_in),
        .CNT_W  (CNT_W)
    ) u_hold (
        .CLK      (CLK),
        .nRST     (nRST),
        .load     (enq_fire && (c != '0) && !deq_final),
        .load_dat (in_enq_v),
        .load_cnt (enq_cnt),
        .take     (deq_final && hold_vld),
        .vld      (hold_vld),
        .dat      (hold_dat),
        .cnt      (hold_cnt)
    );

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            buffer <= '0;
            c      <= '0;
        end else if (deq_fire && !deq_final) begin
            buffer <= buffer >> width_out;
            c      <= c - ONE_CNT;
        end else if (deq_final && hold_vld) begin
            buffer <= hold_dat;
            c      <= hold_cnt;
        end else if (deq_final && enq_fire) begin
            // Hold is empty here, so the new word goes straight in with no bubble.
            buffer <= in_enq_v;
            c      <= enq_cnt;
        end else if (deq_final) begin
            c      <= '0;
        end else if (enq_fire && (c == '0)) begin
            buffer <= in_enq_v;
            c      <= enq_cnt;
        end
    end

endmodule

// File: tb/tb_mimo_unpack.sv
// Scenario bench for mimo_unpack (128 -> 4 x 32) with a chunk scoreboard fed on every accepted enq.
module tb_mimo_unpack;
    import mimo_pkg::*;

    localparam int WI = 128;
    localparam int WO = 32;
    localparam int NC = 4;

    typedef struct packed {
        logic [WO-1:0] dat;
        logic          last;
    } exp_t;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          in_enq_ena;
    logic [WI-1:0] in_enq_v;
    logic [2:0]    in_enq_count;
    logic          in_enq_rdy;
    logic          out_deq_ena;
    logic          out_deq_rdy;
    logic [WO-1:0] out_first;
    logic          out_first_rdy;
    logic          out_last;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    localparam logic [WI-1:0] W1 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [WI-1:0] WA = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    localparam logic [WI-1:0] WB = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    localparam logic [WI-1:0] WC = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;

    mimo_unpack #(.width_in(WI), .width_out(WO)) dut (
        .CLK           (CLK),
        .nRST          (nRST),
        .in_enq_ena    (in_enq_ena),
        .in_enq_v      (in_enq_v),
`ifdef MIMO_UNPACK_PARTIAL_EN
        .in_enq_count  (in_enq_count),
`endif
        .in_enq_rdy    (in_enq_rdy),
        .out_deq_ena   (out_deq_ena),
        .out_deq_rdy   (out_deq_rdy),
        .out_first     (out_first),
        .out_first_rdy (out_first_rdy),
        .out_last      (out_last)
    );

    always #5 CLK = ~CLK;

    // Scoreboard and occupancy invariant, sampled mid-cycle when inputs are stable.
    always @(negedge CLK) begin
        mimo_state_t st;
        int n;
        exp_t e;
        st = (dut.c == '0) ? EMPTY : (dut.hold_vld ? FULL : ACTIVE);
        checks++;
        if ((dut.c == '0) && dut.hold_vld) begin
            errors++;
            $display("FAIL state_invariant: c=0 with hold valid (state %s)", st.name());
        end
        if (!nRST) begin
            q.delete();
        end else begin
            if (out_deq_rdy && out_deq_ena) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got chunk %h last %b, none expected", out_first, out_last);
                end else begin
                    e = q.pop_front();
                    if (out_first !== e.dat || out_last !== e.last) begin
                        errors++;
                        $display("FAIL sb_chunk: got %h last %b, expected %h last %b",
                                 out_first, out_last, e.dat, e.last);
                    end
                end
            end
            if (in_enq_ena && in_enq_rdy) begin
                n = NC;
`ifdef MIMO_UNPACK_PARTIAL_EN
                if (in_enq_count != 0 && in_enq_count <= NC) n = int'(in_enq_count);
`endif
                for (int i = 0; i < n; i++) begin
                    e.dat  = in_enq_v[i*WO +: WO];
                    e.last = (i == n - 1);
                    q.push_back(e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        nRST = 1'b0; in_enq_ena = 1'b0; in_enq_v = '0; in_enq_count = '0; out_deq_ena = 1'b0;
        tick(); tick();
        nRST = 1'b1;
        tick();
        checks++;
        if (in_enq_rdy !== 1'b1 || out_deq_rdy !== 1'b0 || out_first_rdy !== 1'b0 ||
            out_first !== '0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset: enq_rdy %b deq_rdy %b first_rdy %b first %h last %b, expected 1 0 0 0 0",
                     in_enq_rdy, out_deq_rdy, out_first_rdy, out_first, out_last);
        end
    endtask

    task automatic test_single();
        in_enq_ena = 1'b1; in_enq_v = W1; out_deq_ena = 1'b1;
        tick();
        in_enq_ena = 1'b0;
        checks++;
        if (out_first !== 32'h11111111) begin
            errors++;
            $display("FAIL single_latency: first %h, expected 11111111", out_first);
        end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (out_deq_rdy !== 1'b1 || out_last !== (i == NC - 1)) begin
                errors++;
                $display("FAIL single_stream cycle %0d: rdy %b last %b, expected 1 %b",
                         i, out_deq_rdy, out_last, (i == NC - 1));
            end
            tick();
        end
        checks++;
        if (out_deq_rdy !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL single_done: rdy %b pending %0d, expected 0 0", out_deq_rdy, q.size());
        end
    endtask

    task automatic test_back_to_back();
        in_enq_ena = 1'b1; in_enq_v = WA; out_deq_ena = 1'b1;
        tick();
        in_enq_v = WB;
        checks++;
        if (in_enq_rdy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept_b: enq_rdy %b, expected 1", in_enq_rdy);
        end
        tick();
        in_enq_ena = 1'b0;
        for (int i = 0; i < 2 * NC - 1; i++) begin
            checks++;
            if (out_deq_rdy !== 1'b1 || in_enq_rdy !== (i >= NC - 1)) begin
                errors++;
                $display("FAIL b2b_cycle %0d: deq_rdy %b enq_rdy %b, expected 1 %b",
                         i, out_deq_rdy, in_enq_rdy, (i >= NC - 1));
            end
            tick();
        end
        checks++;
        if (out_deq_rdy !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL b2b_done: rdy %b pending %0d, expected 0 0", out_deq_rdy, q.size());
        end
    endtask

    task automatic test_stall();
        in_enq_ena = 1'b1; in_enq_v = W1; out_deq_ena = 1'b1;
        tick();
        in_enq_ena = 1'b0;
        tick();
        out_deq_ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_first !== 32'h22222222 || out_last !== 1'b0 || dut.c !== 3'd3 || in_enq_rdy !== 1'b1) begin
                errors++;
                $display("FAIL stall cycle %0d: first %h last %b c %0d enq_rdy %b, expected 22222222 0 3 1",
                         i, out_first, out_last, dut.c, in_enq_rdy);
            end
            tick();
        end
        out_deq_ena = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (out_deq_rdy !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL stall_done: rdy %b pending %0d, expected 0 0", out_deq_rdy, q.size());
        end
    endtask

    task automatic test_simultaneous();
        in_enq_ena = 1'b1; in_enq_v = W1; out_deq_ena = 1'b1;
        tick();
        in_enq_ena = 1'b0;
        tick(); tick(); tick();
        in_enq_ena = 1'b1; in_enq_v = WC;
        checks++;
        if (out_last !== 1'b1 || in_enq_rdy !== 1'b1) begin
            errors++;
            $display("FAIL simul_setup: last %b enq_rdy %b, expected 1 1", out_last, in_enq_rdy);
        end
        tick();
        in_enq_ena = 1'b0;
        checks++;
        if (out_first !== 32'hC0C0C0C0 || dut.c !== 3'd4 || dut.hold_vld !== 1'b0) begin
            errors++;
            $display("FAIL simul_swap: first %h c %0d hold %b, expected c0c0c0c0 4 0",
                     out_first, dut.c, dut.hold_vld);
        end
        tick(); tick(); tick(); tick();
        checks++;
        if (out_deq_rdy !== 1'b0 || q.size() != 0) begin
            errors++;
            $display("FAIL simul_done: rdy %b pending %0d, expected 0 0", out_deq_rdy, q.size());
        end
    endtask

    task automatic test_reset_mid();
        in_enq_ena = 1'b1; in_enq_v = WA; out_deq_ena = 1'b1;
        tick();
        in_enq_v = WB;
        tick();
        in_enq_ena = 1'b0;
        tick();
        nRST = 1'b0; out_deq_ena = 1'b0;
        tick();
        nRST = 1'b1; out_deq_ena = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (out_deq_rdy !== 1'b0 || out_first !== '0 || in_enq_rdy !== 1'b1 || out_last !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid cycle %0d: deq_rdy %b first %h enq_rdy %b last %b, expected 0 0 1 0",
                         i, out_deq_rdy, out_first, in_enq_rdy, out_last);
            end
            tick();
        end
    endtask

`ifdef MIMO_UNPACK_PARTIAL_EN
    task automatic test_partial();
        logic [2:0] cnts [3];
        int         expn [3];
        cnts[0] = 3'd2; cnts[1] = 3'd0; cnts[2] = 3'd7;
        expn[0] = 2;    expn[1] = 4;    expn[2] = 4;
        for (int k = 0; k < 3; k++) begin
            in_enq_ena = 1'b1; in_enq_v = W1; in_enq_count = cnts[k]; out_deq_ena = 1'b1;
            tick();
            in_enq_ena = 1'b0;
            for (int i = 0; i < expn[k]; i++) begin
                checks++;
                if (out_deq_rdy !== 1'b1 || out_last !== (i == expn[k] - 1)) begin
                    errors++;
                    $display("FAIL partial count %0d cycle %0d: rdy %b last %b, expected 1 %b",
                             cnts[k], i, out_deq_rdy, out_last, (i == expn[k] - 1));
                end
                tick();
            end
            checks++;
            if (out_deq_rdy !== 1'b0) begin
                errors++;
                $display("FAIL partial_done count %0d: rdy %b, expected 0", cnts[k], out_deq_rdy);
            end
        end
        in_enq_count = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_simultaneous();
        test_reset_mid();
`ifdef MIMO_UNPACK_PARTIAL_EN
        test_partial();
`endif
        out_deq_ena = 1'b0;
        tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: %0d chunks outstanding, expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
